// File: rtl/game_flow_if.sv
// ---------------------------------------------------------------------------
// game_flow_if
// Bundles the game sequencer's pulse inputs and status outputs.
//   start_pb, pause_pb   : debounced button pulses (one cycle)
//   good_coll, bad_coll  : collision pulses from the datapath (one cycle)
//   game_complete        : level, snake reached maximum length
//   state[2:0]           : 0=IDLE 1=CLEAR 2=RUN 3=PAUSE 4=OVER 5=WIN
//   sync_reset           : one-cycle game clear pulse
//   move_tick            : one-cycle snake advance pulse
//   speed_level[3:0]     : current speed level 0..15
//   game_over, win       : high while in OVER / WIN
// master drives the inputs (buttons/datapath side), slave is the controller.
// ---------------------------------------------------------------------------
interface game_flow_if;
  logic       start_pb;
  logic       pause_pb;
  logic       good_coll;
  logic       bad_coll;
  logic       game_complete;
  logic [2:0] state;
  logic       sync_reset;
  logic       move_tick;
  logic [3:0] speed_level;
  logic       game_over;
  logic       win;

  modport master (
    output start_pb, pause_pb, good_coll, bad_coll, game_complete,
    input  state, sync_reset, move_tick, speed_level, game_over, win
  );

  modport slave (
    input  start_pb, pause_pb, good_coll, bad_coll, game_complete,
    output state, sync_reset, move_tick, speed_level, game_over, win
  );
endinterface

// File: rtl/game_flow_controller.sv
// ---------------------------------------------------------------------------
// game_flow_controller
// Top-level game sequencer for the snake design. Owns the game phase FSM,
// issues the one-cycle sync_reset clear and schedules move_tick with a
// period that shrinks as apples are eaten.
//
// Ports:
//   clk   : system clock
//   nrst  : asynchronous active-low reset
//   gf    : game_flow_if.slave (button/collision pulses in, status out)
//
// Optional feature (macro AUTO_RESTART_EN): when defined, OVER returns to
// CLEAR by itself after OVER_HOLD cycles; start_pb still restarts early.
// When undefined no hold counter exists and OVER waits for start_pb.
//
// state | meaning
// IDLE  | power-up, waiting for start_pb
// CLEAR | one cycle, sync_reset high, level and timer re-armed
// RUN   | timer running, move_tick issued every period
// PAUSE | timer frozen, waiting for pause_pb (resume) or start_pb (restart)
// OVER  | collision ended the game, game_over high
// WIN   | maximum length reached, win high
// ---------------------------------------------------------------------------
module game_flow_controller #(
  parameter int unsigned TICK_BASE       = 1_500_000,
  parameter int unsigned TICK_STEP       = 100_000,
  parameter int unsigned TICK_MIN        = 300_000,
  parameter int unsigned SCORE_PER_LEVEL = 5,
  parameter int unsigned OVER_HOLD       = 24_000_000
) (
  input logic       clk,
  input logic       nrst,
  game_flow_if.slave gf
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic [31:0] sub_q, sub_d;
  logic [3:0]  level_q, level_d;
  logic        sync_reset_q, sync_reset_d;
  logic        move_tick_q, move_tick_d;
  logic        game_over_q, game_over_d;
  logic        win_q, win_d;
  logic        run_exit;

`ifdef AUTO_RESTART_EN
  logic [31:0] hold_cnt_q, hold_cnt_d;
`endif

  // Move period for a given level, clamped to TICK_MIN without underflow.
  function automatic logic [31:0] period_f(input logic [3:0] lvl);
    logic [31:0] dec;
    dec = 32'(lvl) * TICK_STEP;
    if (dec > (TICK_BASE - TICK_MIN)) begin
      return TICK_MIN;
    end
    return TICK_BASE - dec;
  endfunction

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    sub_d       = sub_q;
    level_d     = level_q;
    move_tick_d = 1'b0;
    run_exit    = 1'b0;
`ifdef AUTO_RESTART_EN
    hold_cnt_d  = hold_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (gf.start_pb) state_d = S_CLEAR;
      end

      // The CLEAR cycle counts as the first cycle of the first period, so the
      // first move_tick lands exactly TICK_BASE cycles after sync_reset.
      S_CLEAR: begin
        state_d = S_RUN;
        if (tick_cnt_q != 32'd0) tick_cnt_d = tick_cnt_q - 32'd1;
      end

      S_RUN: begin
        run_exit = gf.bad_coll | gf.game_complete | gf.pause_pb;
        if (gf.bad_coll)           state_d = S_OVER;
        else if (gf.game_complete) state_d = S_WIN;
        else if (gf.pause_pb)      state_d = S_PAUSE;

        // On an exit that coincides with expiry the count stays at zero, so a
        // resume from PAUSE ticks on the following cycle.
        if (tick_cnt_q == 32'd0) begin
          if (!run_exit) begin
            move_tick_d = 1'b1;
            tick_cnt_d  = period_f(level_q) - 32'd1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q - 32'd1;
        end

        if (gf.good_coll && !run_exit) begin
          if (sub_q >= SCORE_PER_LEVEL - 32'd1) begin
            sub_d = 32'd0;
            if (level_q != 4'd15) level_d = level_q + 4'd1;
          end else begin
            sub_d = sub_q + 32'd1;
          end
        end
      end

      S_PAUSE: begin
        if (gf.start_pb)      state_d = S_CLEAR;
        else if (gf.pause_pb) state_d = S_RUN;
      end

      S_OVER: begin
        if (gf.start_pb) begin
          state_d = S_CLEAR;
        end
`ifdef AUTO_RESTART_EN
        else if (hold_cnt_q == 32'd0) begin
          state_d = S_CLEAR;
        end else begin
          hold_cnt_d = hold_cnt_q - 32'd1;
        end
`endif
      end

      S_WIN: begin
        if (gf.start_pb) state_d = S_CLEAR;
      end

      default: state_d = S_IDLE;
    endcase

    // Every path into CLEAR re-arms the game, whichever state it came from.
    if (state_d == S_CLEAR) begin
      tick_cnt_d = TICK_BASE - 32'd1;
      sub_d      = 32'd0;
      level_d    = 4'd0;
    end

`ifdef AUTO_RESTART_EN
    // Loaded on entry; reaching zero in OVER means OVER_HOLD cycles elapsed.
    if (state_d == S_OVER && state_q != S_OVER) begin
      hold_cnt_d = OVER_HOLD - 32'd1;
    end
`endif

    sync_reset_d = (state_d == S_CLEAR);
    game_over_d  = (state_d == S_OVER);
    win_d        = (state_d == S_WIN);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= 32'd0;
      sub_q        <= 32'd0;
      level_q      <= 4'd0;
      sync_reset_q <= 1'b0;
      move_tick_q  <= 1'b0;
      game_over_q  <= 1'b0;
      win_q        <= 1'b0;
`ifdef AUTO_RESTART_EN
      hold_cnt_q   <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      sub_q        <= sub_d;
      level_q      <= level_d;
      sync_reset_q <= sync_reset_d;
      move_tick_q  <= move_tick_d;
      game_over_q  <= game_over_d;
      win_q        <= win_d;
`ifdef AUTO_RESTART_EN
      hold_cnt_q   <= hold_cnt_d;
`endif
    end
  end

  assign gf.state       = state_q;
  assign gf.sync_reset  = sync_reset_q;
  assign gf.move_tick   = move_tick_q;
  assign gf.speed_level = level_q;
  assign gf.game_over   = game_over_q;
  assign gf.win         = win_q;

endmodule
